// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL bring-up / reconfiguration controller.
// Holds the FSM state encoding, counter widths and the idle values for the APB bus.
package pll_ctrl_pkg;

    localparam int TMR_W       = 16;
    localparam int STEP_W      = 8;
    localparam int RETRY_W     = 4;
    localparam int LOCK_QUAL_W = 2;

    // Four consecutive synchronised highs are needed before lock is trusted
    localparam logic [LOCK_QUAL_W-1:0] LOCK_QUAL_MAX = 2'd3;

    localparam logic [4:0]  APB_ADDR_IDLE  = 5'h00;
    localparam logic [15:0] APB_WDATA_IDLE = 16'h0000;

    typedef enum logic [3:0] {
        ST_PWD,
        ST_RST,
        ST_WAIT_LOCK,
        ST_READY,
        ST_APB_SETUP,
        ST_APB_ACCESS,
        ST_PS_PULSE,
        ST_PS_WAIT,
        ST_FAULT
    } pll_state_e;

endpackage

// File: rtl/pll_lock_sync.sv
// Brings the asynchronous PLL lock into apb_clk and qualifies it: lock_s rises only
// after four consecutive synchronised highs and drops on the first synchronised low.
import pll_ctrl_pkg::*;

module pll_lock_sync (
    input  logic apb_clk,
    input  logic apb_rst_n,
    input  logic lock_async,
    output logic lock_s
);

    logic                   sync1;
    logic                   sync2;
    logic [LOCK_QUAL_W-1:0] qual_cnt;

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            qual_cnt <= '0;
            lock_s   <= 1'b0;
        end else begin
            sync1 <= lock_async;
            sync2 <= sync1;
            if (!sync2) begin
                qual_cnt <= '0;
                lock_s   <= 1'b0;
            end else if (qual_cnt == LOCK_QUAL_MAX) begin
                lock_s <= 1'b1;
            end else begin
                qual_cnt <= qual_cnt + LOCK_QUAL_W'(1);
            end
        end
    end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// Bring-up, relock and reconfiguration sequencer for one PLL with APB and DPS ports.
// One shared down-counter times PWD/RST/lock-wait/bus-wait; a separate counter tracks phase steps.
//
// state      | meaning
// -----------+------------------------------------------------------------
// PWD        | PLL powered down and held in reset
// RST        | power applied, PLL held in reset
// WAIT_LOCK  | reset released, waiting for qualified lock (with timeout)
// READY      | locked, idle; accepts cfg and phase-step requests
// APB_SETUP  | APB setup phase, address/data/direction driven
// APB_ACCESS | APB access phase, waiting for apb_ready
// PS_PULSE   | one-cycle dps_en pulse
// PS_WAIT    | waiting for dps_done of the current step
// FAULT      | lock retries or bus wait exhausted; terminal until reset
import pll_ctrl_pkg::*;

module pll_reconfig_ctrl #(
    parameter int PWD_CYCLES   = 16,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int MAX_RETRY    = 3,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic        apb_clk,
    input  logic        apb_rst_n,
    input  logic        pll_lock,
    output logic        pll_pwd,
    output logic        pll_rst,
    output logic [4:0]  apb_addr,
    output logic        apb_sel,
    output logic        apb_en,
    output logic        apb_write,
    output logic [15:0] apb_wdata,
    input  logic [15:0] apb_rdata,
    input  logic        apb_ready,
    output logic        dps_en,
    output logic        dps_dir,
    input  logic        dps_done,
    input  logic        cfg_req,
    input  logic        cfg_wr,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        cfg_ack,
    output logic [15:0] cfg_rdata,
    input  logic        ps_req,
    input  logic        ps_dir,
    input  logic [7:0]  ps_steps,
    output logic        ps_ack,
    output logic        pll_ready,
    output logic        fault,
    output logic [7:0]  relock_cnt
);

    localparam logic [TMR_W-1:0]   PWD_LOAD    = TMR_W'(PWD_CYCLES - 1);
    localparam logic [TMR_W-1:0]   RST_LOAD    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   LOCK_LOAD   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   BUS_LOAD    = TMR_W'(BUS_TIMEOUT - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    pll_state_e          state, state_nxt;
    logic [TMR_W-1:0]    tmr, tmr_nxt;
    logic [RETRY_W-1:0]  retry, retry_nxt, retry_inc;
    logic [STEP_W-1:0]   steps, steps_nxt;
    logic [4:0]          addr_nxt;
    logic [15:0]         wdata_nxt;
    logic                write_nxt;
    logic                dir_nxt;
    logic                cfg_ack_nxt;
    logic                ps_ack_nxt;
    logic [15:0]         rdata_nxt;
    logic                fault_nxt;
    logic [7:0]          relock_nxt;
    logic                lock_s;
    logic                tmr_tc;

    pll_lock_sync u_lock_sync (
        .apb_clk    (apb_clk),
        .apb_rst_n  (apb_rst_n),
        .lock_async (pll_lock),
        .lock_s     (lock_s)
    );

    assign tmr_tc    = (tmr == '0);
    assign retry_inc = retry + RETRY_W'(1);

    always_ff @(posedge apb_clk or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            state      <= ST_PWD;
            tmr        <= PWD_LOAD;
            retry      <= '0;
            steps      <= '0;
            apb_addr   <= APB_ADDR_IDLE;
            apb_wdata  <= APB_WDATA_IDLE;
            apb_write  <= 1'b0;
            dps_dir    <= 1'b0;
            cfg_ack    <= 1'b0;
            ps_ack     <= 1'b0;
            cfg_rdata  <= '0;
            fault      <= 1'b0;
            relock_cnt <= '0;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            retry      <= retry_nxt;
            steps      <= steps_nxt;
            apb_addr   <= addr_nxt;
            apb_wdata  <= wdata_nxt;
            apb_write  <= write_nxt;
            dps_dir    <= dir_nxt;
            cfg_ack    <= cfg_ack_nxt;
            ps_ack     <= ps_ack_nxt;
            cfg_rdata  <= rdata_nxt;
            fault      <= fault_nxt;
            relock_cnt <= relock_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        retry_nxt   = retry;
        steps_nxt   = steps;
        addr_nxt    = apb_addr;
        wdata_nxt   = apb_wdata;
        write_nxt   = apb_write;
        dir_nxt     = dps_dir;
        cfg_ack_nxt = 1'b0;
        ps_ack_nxt  = 1'b0;
        rdata_nxt   = cfg_rdata;
        fault_nxt   = fault;
        relock_nxt  = relock_cnt;

        case (state)
            ST_PWD: begin
                if (tmr_tc) begin
                    state_nxt = ST_RST;
                    tmr_nxt   = RST_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_RST: begin
                if (tmr_tc) begin
                    state_nxt = ST_WAIT_LOCK;
                    tmr_nxt   = LOCK_LOAD;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = ST_READY;
                    retry_nxt = '0;
                end else if (tmr_tc) begin
                    retry_nxt = retry_inc;
                    if (retry_inc == RETRY_LIMIT) begin
                        state_nxt = ST_FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_RST;
                        tmr_nxt   = RST_LOAD;
                    end
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_READY: begin
                if (!lock_s) begin
                    if (relock_cnt != 8'hFF) relock_nxt = relock_cnt + 8'd1;
                    state_nxt = ST_RST;
                    tmr_nxt   = RST_LOAD;
                end else if (cfg_req) begin
                    state_nxt = ST_APB_SETUP;
                    addr_nxt  = cfg_addr;
                    wdata_nxt = cfg_wdata;
                    write_nxt = cfg_wr;
                end else if (ps_req) begin
                    if (ps_steps == '0) begin
                        ps_ack_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_PS_PULSE;
                        steps_nxt = ps_steps;
                        dir_nxt   = ps_dir;
                    end
                end
            end
            ST_APB_SETUP: begin
                state_nxt = ST_APB_ACCESS;
                tmr_nxt   = BUS_LOAD;
            end
            ST_APB_ACCESS: begin
                if (apb_ready) begin
                    cfg_ack_nxt = 1'b1;
                    addr_nxt    = APB_ADDR_IDLE;
                    wdata_nxt   = APB_WDATA_IDLE;
                    write_nxt   = 1'b0;
                    // A write changes PLL settings, so always go through a full relock
                    if (apb_write) begin
                        state_nxt = ST_RST;
                        tmr_nxt   = RST_LOAD;
                        retry_nxt = '0;
                    end else begin
                        state_nxt = ST_READY;
                        rdata_nxt = apb_rdata;
                    end
                end else if (tmr_tc) begin
                    state_nxt = ST_FAULT;
                    fault_nxt = 1'b1;
                    addr_nxt  = APB_ADDR_IDLE;
                    wdata_nxt = APB_WDATA_IDLE;
                    write_nxt = 1'b0;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_PS_PULSE: begin
                state_nxt = ST_PS_WAIT;
                tmr_nxt   = BUS_LOAD;
            end
            ST_PS_WAIT: begin
                if (dps_done) begin
                    if (steps == STEP_W'(1)) begin
                        ps_ack_nxt = 1'b1;
                        state_nxt  = ST_READY;
                    end else begin
                        state_nxt = ST_PS_PULSE;
                    end
                    steps_nxt = steps - STEP_W'(1);
                end else if (tmr_tc) begin
                    state_nxt = ST_FAULT;
                    fault_nxt = 1'b1;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FAULT;
                fault_nxt = 1'b1;
            end
        endcase
    end

    // Outputs decode straight from registered state so reset takes effect in the same cycle
    assign pll_pwd   = (state == ST_PWD) || (state == ST_FAULT);
    assign pll_rst   = (state == ST_PWD) || (state == ST_RST) || (state == ST_FAULT) ||
                       (((state == ST_APB_SETUP) || (state == ST_APB_ACCESS)) && apb_write);
    assign apb_sel   = (state == ST_APB_SETUP) || (state == ST_APB_ACCESS);
    assign apb_en    = (state == ST_APB_ACCESS);
    assign dps_en    = (state == ST_PS_PULSE);
    assign pll_ready = (state == ST_READY);

endmodule
